controle_multdiv: RTL and testbench

- Sequencer between the CPU control unit and the shared MULT/DIV datapath units; each unit has a start/fim handshake and hi/lo result buses.
- Accepts MULT/DIV requests, holds operands stable and drives the selected unit's start for the whole run.
- Detects completion, commits results into the architectural HI/LO registers and stalls the CPU while busy.
- Also handles divide-by-zero and a hung unit (timeout).

---
 rtl/controle_multdiv_pkg.sv | 20 ++
 rtl/controle_multdiv_contador_timeout.sv | 31 +++
 rtl/controle_multdiv.sv | 119 +++++++++++
 tb/tb_controle_multdiv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/controle_multdiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: state and unit-select encodings,
// default sizing.
package controle_multdiv_pkg;

  localparam int LARGURA_PADRAO    = 32;
  localparam int MAX_CICLOS_PADRAO = 40;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DISPARO = 2'd1,
    EXECUTA = 2'd2,
    GRAVA   = 2'd3
  } estado_t;

  typedef enum logic {
    SEL_MULT = 1'b0,
    SEL_DIV  = 1'b1
  } unidade_t;

endpackage

// File: rtl/controle_multdiv_contador_timeout.sv
// Run-length watchdog: counts cycles while enabled and flags the last allowed cycle.
module contador_timeout
  import controle_multdiv_pkg::*;
#(
  parameter int MAX_CICLOS = MAX_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;
  localparam logic [W-1:0] LIMITE = W'(MAX_CICLOS - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable && !terminal) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign terminal = (contagem == LIMITE);

endmodule

// File: rtl/controle_multdiv.sv
// Sequencer between the CPU and the shared MULT/DIV units: launches a run,
// commits HI/LO on completion, stalls the CPU, handles div-by-zero and a hung unit.
//
// state   | meaning
// OCIOSO  | idle, accepting MULT/DIV requests
// DISPARO | start raised, waiting for the unit to drop fim
// EXECUTA | unit running, waiting for fim to rise
// GRAVA   | commit cycle, HI/LO load on exit
module controle_multdiv
  import controle_multdiv_pkg::*;
#(
  parameter int MAX_CICLOS = MAX_CICLOS_PADRAO,
  parameter int LARGURA    = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               op_mult,
  input  logic               op_div,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  output logic [LARGURA-1:0] unidade_op1,
  output logic [LARGURA-1:0] unidade_op2,
  output logic               mult_start,
  input  logic               mult_fim,
  input  logic [LARGURA-1:0] mult_hi,
  input  logic [LARGURA-1:0] mult_lo,
  output logic               div_start,
  input  logic               div_fim,
  input  logic [LARGURA-1:0] div_hi,
  input  logic [LARGURA-1:0] div_lo,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo,
  output logic               ocupado,
  output logic               pronto,
  output logic               div_zero,
  output logic               timeout
);

  estado_t  estado, proximo;
  unidade_t sel;
  logic     em_curso, fim_sel, terminal, div_zero_req, pedido;

  assign pedido       = op_mult || op_div;
  assign div_zero_req = op_div && !op_mult && (operando_b == '0);
  assign fim_sel      = (sel == SEL_DIV) ? div_fim : mult_fim;

  contador_timeout #(.MAX_CICLOS(MAX_CICLOS)) u_contador (
    .clock    (clock),
    .reset    (reset),
    .clear    (estado == OCIOSO),
    .enable   (em_curso),
    .terminal (terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo    = estado;
    em_curso   = 1'b0;
    ocupado    = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (pedido && !div_zero_req) proximo = DISPARO;
      end
      DISPARO: begin
        em_curso = 1'b1;
        ocupado  = 1'b1;
        // a fim still high here is left over from idle, not completion
        if (terminal)      proximo = OCIOSO;
        else if (!fim_sel) proximo = EXECUTA;
      end
      EXECUTA: begin
        em_curso = 1'b1;
        ocupado  = 1'b1;
        if (fim_sel)       proximo = GRAVA;
        else if (terminal) proximo = OCIOSO;
      end
      GRAVA: begin
        ocupado = 1'b1;
        proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
    mult_start = em_curso && (sel == SEL_MULT);
    div_start  = em_curso && (sel == SEL_DIV);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel         <= SEL_MULT;
      unidade_op1 <= '0;
      unidade_op2 <= '0;
      hi          <= '0;
      lo          <= '0;
      pronto      <= 1'b0;
      div_zero    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      pronto   <= (estado == GRAVA);
      div_zero <= (estado == OCIOSO) && div_zero_req;
      timeout  <= em_curso && (proximo == OCIOSO);
      if (estado == OCIOSO && pedido) begin
        unidade_op1 <= operando_a;
        unidade_op2 <= operando_b;
        sel         <= op_mult ? SEL_MULT : SEL_DIV;
      end
      if (estado == GRAVA) begin
        hi <= (sel == SEL_DIV) ? div_hi : mult_hi;
        lo <= (sel == SEL_DIV) ? div_lo : mult_lo;
      end
    end
  end

endmodule

// File: tb/tb_controle_multdiv.sv
// Bench for controle_multdiv: behavioural MULT/DIV unit models, an arithmetic
// HI/LO model checked every cycle, and directed timing checks per operation.
module tb_controle_multdiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_mult = 1'b0, op_div = 1'b0;
  logic [31:0] operando_a = '0, operando_b = '0;
  logic [31:0] unidade_op1, unidade_op2;
  logic        mult_start, mult_fim, div_start, div_fim;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo, hi, lo;
  logic        ocupado, pronto, div_zero, timeout;

  int total = 0;
  int bad   = 0;

  controle_multdiv dut (
    .clock(clock), .reset(reset), .op_mult(op_mult), .op_div(op_div),
    .operando_a(operando_a), .operando_b(operando_b),
    .unidade_op1(unidade_op1), .unidade_op2(unidade_op2),
    .mult_start(mult_start), .mult_fim(mult_fim), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_fim(div_fim), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .ocupado(ocupado), .pronto(pronto),
    .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // unit models: fim drops the cycle after start rises, rises lat cycles later
  int   mult_lat = 4, div_lat = 4;
  bit   hang_mult = 0;
  logic m_busy, m_armed, d_busy, d_armed;
  int   m_cnt, d_cnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_armed <= 1'b1; m_cnt <= 0; mult_hi <= '0; mult_lo <= '0;
    end else if (!mult_start) begin
      m_busy <= 1'b0; m_armed <= 1'b1;
    end else if (m_armed) begin
      m_armed <= 1'b0;
      if (!hang_mult) begin m_busy <= 1'b1; m_cnt <= mult_lat; end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        {mult_hi, mult_lo} <= $signed({{32{unidade_op1[31]}}, unidade_op1}) *
                              $signed({{32{unidade_op2[31]}}, unidade_op2});
      end else m_cnt <= m_cnt - 1;
    end
  end
  assign mult_fim = !m_busy;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      d_busy <= 1'b0; d_armed <= 1'b1; d_cnt <= 0; div_hi <= '0; div_lo <= '0;
    end else if (!div_start) begin
      d_busy <= 1'b0; d_armed <= 1'b1;
    end else if (d_armed) begin
      d_armed <= 1'b0; d_busy <= 1'b1; d_cnt <= div_lat;
    end else if (d_busy) begin
      if (d_cnt == 1) begin
        d_busy <= 1'b0;
        div_lo <= $signed(unidade_op1) / $signed(unidade_op2);
        div_hi <= $signed(unidade_op1) % $signed(unidade_op2);
      end else d_cnt <= d_cnt - 1;
    end
  end
  assign div_fim = !d_busy;

  // architectural model: HI/LO change only on pronto, and then to the arithmetic result
  logic [63:0] committed = '0, pend = '0;
  bit          pend_valid = 0;

  always @(negedge clock) begin
    if (!reset) begin
      chk("one_start", 64'(mult_start && div_start), 64'd0);
      chk("start_implies_ocupado", 64'((mult_start || div_start) && !ocupado), 64'd0);
      if (pronto) begin
        chk("pronto_expected", 64'(pend_valid), 64'd1);
        chk("hilo_commit", {hi, lo}, pend);
        committed = pend;
        pend_valid = 0;
      end else begin
        chk("hilo_hold", {hi, lo}, committed);
      end
    end
  end

  int r_pr_at, r_to_at, r_dz_at, r_pr_cnt, r_to_cnt, r_dz_cnt, r_ms, r_ds, r_occ, r_moved;

  task automatic run_req(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_res, input bit poke_a);
    int n = 0;
    int tail = -1;
    r_pr_at = -1; r_to_at = -1; r_dz_at = -1;
    r_pr_cnt = 0; r_to_cnt = 0; r_dz_cnt = 0; r_ms = 0; r_ds = 0; r_occ = 0; r_moved = 0;
    if (exp_res) begin
      if (m) pend = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else   pend = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      pend_valid = 1;
    end
    @(posedge clock); #1;
    op_mult = m; op_div = d; operando_a = a; operando_b = b;
    @(posedge clock); #1;
    op_mult = 0; op_div = 0;
    while (n < 300 && tail != 0) begin
      @(negedge clock);
      n++;
      if (poke_a && n == 5) operando_a = ~a;
      if (mult_start) r_ms++;
      if (div_start)  r_ds++;
      if (ocupado)    r_occ++;
      if (ocupado && (unidade_op1 !== a || unidade_op2 !== b)) r_moved++;
      if (pronto)   begin r_pr_cnt++; if (r_pr_at < 0) r_pr_at = n; end
      if (timeout)  begin r_to_cnt++; if (r_to_at < 0) r_to_at = n; end
      if (div_zero) begin r_dz_cnt++; if (r_dz_at < 0) r_dz_at = n; end
      if (tail > 0) tail--;
      else if (tail < 0 && (pronto || timeout || div_zero)) tail = 3;
    end
    chk("end_event_within_bound", 64'(tail == 0), 64'd1);
  endtask

  initial begin
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_op1", 64'(unidade_op1), 64'd0);
    chk("rst_op2", 64'(unidade_op2), 64'd0);
    chk("rst_flags", 64'({mult_start, div_start, ocupado, pronto, div_zero, timeout}), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // MULT 3x5, 33-cycle unit
    mult_lat = 33;
    run_req(1, 0, 32'd3, 32'd5, 1, 0);
    chk("m35_pronto_at", 64'(r_pr_at), 64'd37);
    chk("m35_pronto_cnt", 64'(r_pr_cnt), 64'd1);
    chk("m35_mult_start_cycles", 64'(r_ms), 64'd35);
    chk("m35_div_start_cycles", 64'(r_ds), 64'd0);
    chk("m35_ocupado_cycles", 64'(r_occ), 64'd36);
    chk("m35_hi", 64'(hi), 64'd0);
    chk("m35_lo", 64'(lo), 64'd15);

    // signed -1 x 2, operando_a disturbed mid-run
    mult_lat = 6;
    run_req(1, 0, 32'hFFFF_FFFF, 32'd2, 1, 1);
    chk("mneg_pronto_at", 64'(r_pr_at), 64'd10);
    chk("mneg_operands_stable", 64'(r_moved), 64'd0);
    chk("mneg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mneg_lo", 64'(lo), 64'hFFFF_FFFE);

    // DIV 17/5
    div_lat = 10;
    run_req(0, 1, 32'd17, 32'd5, 1, 0);
    chk("d175_pronto_at", 64'(r_pr_at), 64'd14);
    chk("d175_div_start_cycles", 64'(r_ds), 64'd12);
    chk("d175_mult_start_cycles", 64'(r_ms), 64'd0);
    chk("d175_hi", 64'(hi), 64'd2);
    chk("d175_lo", 64'(lo), 64'd3);

    // DIV 9/0
    run_req(0, 1, 32'd9, 32'd0, 0, 0);
    chk("dz_at", 64'(r_dz_at), 64'd1);
    chk("dz_cnt", 64'(r_dz_cnt), 64'd1);
    chk("dz_div_start_cycles", 64'(r_ds), 64'd0);
    chk("dz_ocupado_cycles", 64'(r_occ), 64'd0);
    chk("dz_pronto_cnt", 64'(r_pr_cnt), 64'd0);
    chk("dz_hi", 64'(hi), 64'd2);
    chk("dz_lo", 64'(lo), 64'd3);

    // simultaneous requests: mult wins
    mult_lat = 4;
    run_req(1, 1, 32'd6, 32'd7, 1, 0);
    chk("both_div_start_cycles", 64'(r_ds), 64'd0);
    chk("both_mult_start_cycles", 64'(r_ms), 64'd6);
    chk("both_lo", 64'(lo), 64'd42);

    // hung multiplier
    hang_mult = 1;
    run_req(1, 0, 32'd8, 32'd9, 0, 0);
    chk("to_at", 64'(r_to_at), 64'd41);
    chk("to_cnt", 64'(r_to_cnt), 64'd1);
    chk("to_mult_start_cycles", 64'(r_ms), 64'd40);
    chk("to_ocupado_cycles", 64'(r_occ), 64'd40);
    chk("to_pronto_cnt", 64'(r_pr_cnt), 64'd0);
    chk("to_hilo", {hi, lo}, {32'd0, 32'd42});
    hang_mult = 0;
    mult_lat = 5;
    run_req(1, 0, 32'd4, 32'd5, 1, 0);
    chk("after_to_pronto_at", 64'(r_pr_at), 64'd9);
    chk("after_to_lo", 64'(lo), 64'd20);

    // reset in the middle of EXECUTA
    mult_lat = 33;
    @(posedge clock); #1;
    op_mult = 1; operando_a = 32'd11; operando_b = 32'd13;
    @(posedge clock); #1;
    op_mult = 0;
    repeat (10) @(negedge clock);
    chk("pre_rst_running", 64'({mult_start, ocupado}), 64'b11);
    #2;
    reset = 1'b1;
    pend_valid = 0;
    committed = '0;
    #1;
    chk("async_rst_start", 64'(mult_start), 64'd0);
    chk("async_rst_ocupado", 64'(ocupado), 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mult_lat = 3;
    run_req(1, 0, 32'd2, 32'd7, 1, 0);
    chk("post_rst_pronto_cnt", 64'(r_pr_cnt), 64'd1);
    chk("post_rst_lo", 64'(lo), 64'd14);
    chk("post_rst_hi", 64'(hi), 64'd0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout want completion");
    $fatal(1);
  end

endmodule
